// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM driver: default command width,
// the fetch FSM state type, and a sizing helper for the watchdog counter.
package motor_pkg;

  localparam int MOTOR_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_CAPTURE = 1'b1
  } fetch_state_t;

  // The watchdog counter has to hold the terminal count itself, because it
  // saturates there.
  function automatic int wdog_width(input int periods);
    return (periods < 1) ? 1 : $clog2(periods + 1);
  endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Read-side handshake of the paired left/right speed-command FIFOs.
//   i_left_motor / i_right_motor : FIFO read data, valid the cycle after rd_en
//   i_left_empty / i_right_empty : FIFO empty flags
//   o_left_rd_en / o_right_rd_en : FIFO pop strobes
// master = the command consumer (motor_pwm_driver), slave = the FIFO pair.
interface motor_pwm_driver_if
  import motor_pkg::*;
#(
  parameter int MW = MOTOR_WIDTH_DEFAULT
) ();

  logic [MW-1:0] i_left_motor;
  logic          i_left_empty;
  logic          o_left_rd_en;
  logic [MW-1:0] i_right_motor;
  logic          i_right_empty;
  logic          o_right_rd_en;

  modport master (
    input  i_left_motor, i_left_empty, i_right_motor, i_right_empty,
    output o_left_rd_en, o_right_rd_en
  );

  modport slave (
    output i_left_motor, i_left_empty, i_right_motor, i_right_empty,
    input  o_left_rd_en, o_right_rd_en
  );

endinterface

// File: rtl/pwm_channel.sv
// One motor channel: target register, per-period slew-limited duty and the
// registered PWM compare.
//   clk, reset  : clock, synchronous active-high reset
//   pwm_cnt     : shared PWM period counter
//   period_end  : strobe on the last tick-cycle of a PWM period
//   load        : capture target_in as the new target
//   target_in   : command value from the FIFO
//   force_zero  : watchdog expiry, drive the target to 0 (load has priority)
//   duty        : currently applied duty
//   pwm         : PWM output, one cycle behind the compare
module pwm_channel
  import motor_pkg::*;
#(
  parameter int MW        = MOTOR_WIDTH_DEFAULT,
  parameter int SLEW_STEP = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [MW-1:0] pwm_cnt,
  input  logic          period_end,
  input  logic          load,
  input  logic [MW-1:0] target_in,
  input  logic          force_zero,
  output logic [MW-1:0] duty,
  output logic          pwm
);

  // A step of 2**MW-1 or more already reaches any target in one period, so
  // clamping keeps the step representable in the MW+1-bit signed domain.
  localparam int STEP_CLAMP = (SLEW_STEP > (2**MW - 1)) ? (2**MW - 1) : SLEW_STEP;
  localparam logic signed [MW:0] STEP_S = $signed((MW+1)'(STEP_CLAMP));

  logic [MW-1:0] target_p0;
  logic [MW-1:0] duty_p0;
  logic          pwm_p1;

  // Move cur toward tgt by at most STEP_S; overshoot is impossible because
  // the full step is only taken when the distance exceeds it.
  function automatic logic [MW-1:0] slew_toward(input logic [MW-1:0] cur,
                                                input logic [MW-1:0] tgt);
    logic signed [MW:0] cur_s;
    logic signed [MW:0] tgt_s;
    logic signed [MW:0] diff;
    logic signed [MW:0] nxt;
    cur_s = $signed({1'b0, cur});
    tgt_s = $signed({1'b0, tgt});
    diff  = tgt_s - cur_s;
    if (diff > STEP_S)
      nxt = cur_s + STEP_S;
    else if (diff < -STEP_S)
      nxt = cur_s - STEP_S;
    else
      nxt = tgt_s;
    return nxt[MW-1:0];
  endfunction

  // Stage p0: target and duty registers; slew reads the pre-capture target.
  always_ff @(posedge clk) begin
    if (reset) begin
      target_p0 <= '0;
      duty_p0   <= '0;
      pwm_p1    <= 1'b0;
    end else begin
      if (load)
        target_p0 <= target_in;
      else if (force_zero)
        target_p0 <= '0;
      if (period_end)
        duty_p0 <= slew_toward(duty_p0, target_p0);
      // Stage p1: registered compare.
      pwm_p1 <= (pwm_cnt < duty_p0);
    end
  end

  assign duty = duty_p0;
  assign pwm  = pwm_p1;

endmodule

// File: rtl/motor_pwm_driver.sv
// Pops paired left/right speed commands and drives two slew-limited PWM
// outputs, with a watchdog that ramps both motors to stop when commands stall.
//   clk, reset     : clock, synchronous active-high reset
//   fifo           : FIFO read handshake (master side)
//   o_left_pwm     : left motor PWM
//   o_right_pwm    : right motor PWM
//   o_left_duty    : applied left duty
//   o_right_duty   : applied right duty
//   o_period_end   : strobe on the last tick-cycle of each PWM period
//   o_timeout      : watchdog expired, held until the next command capture
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int MOTOR_WIDTH      = MOTOR_WIDTH_DEFAULT,
  parameter int CLK_DIV          = 196,
  parameter int SLEW_STEP        = 8,
  parameter int WATCHDOG_PERIODS = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  motor_pwm_driver_if.master     fifo,
  output logic                   o_left_pwm,
  output logic                   o_right_pwm,
  output logic [MOTOR_WIDTH-1:0] o_left_duty,
  output logic [MOTOR_WIDTH-1:0] o_right_duty,
  output logic                   o_period_end,
  output logic                   o_timeout
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WD_W = wdog_width(WATCHDOG_PERIODS);
  localparam logic [PS_W-1:0] PS_MAX  = PS_W'(CLK_DIV - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WATCHDOG_PERIODS);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_PERIODS - 1);

  fetch_state_t           state;
  logic [PS_W-1:0]        prescaler;
  logic [MOTOR_WIDTH-1:0] pwm_cnt;
  logic [WD_W-1:0]        wdog;
  logic                   timeout;
  logic                   tick;
  logic                   period_end;
  logic                   fetch;
  logic                   capture;
  logic                   expire;

  assign tick       = (prescaler == PS_MAX);
  assign period_end = tick && (pwm_cnt == '1);
  assign capture    = (state == S_CAPTURE);
  // Gating with reset keeps the FIFOs untouched while reset is held, even
  // though the state register is already IDLE.
  assign fetch      = !reset && (state == S_IDLE) &&
                      !fifo.i_left_empty && !fifo.i_right_empty;
  // A capture in the same cycle restarts the watchdog instead.
  assign expire     = period_end && !capture && (wdog == WD_LAST);

  assign fifo.o_left_rd_en  = fetch;
  assign fifo.o_right_rd_en = fetch;

  // Stage p0: fetch FSM. CAPTURE always lasts one cycle, which limits the
  // pop rate to one pair per two cycles.
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else if (fetch)
      state <= S_CAPTURE;
    else
      state <= S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else if (capture) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else if (period_end && (wdog != WD_MAX)) begin
      wdog <= wdog + 1'b1;
      if (expire)
        timeout <= 1'b1;
    end
  end

  pwm_channel #(.MW(MOTOR_WIDTH), .SLEW_STEP(SLEW_STEP)) u_left (
    .clk        (clk),
    .reset      (reset),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end),
    .load       (capture),
    .target_in  (fifo.i_left_motor),
    .force_zero (expire),
    .duty       (o_left_duty),
    .pwm        (o_left_pwm)
  );

  pwm_channel #(.MW(MOTOR_WIDTH), .SLEW_STEP(SLEW_STEP)) u_right (
    .clk        (clk),
    .reset      (reset),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end),
    .load       (capture),
    .target_in  (fifo.i_right_motor),
    .force_zero (expire),
    .duty       (o_right_duty),
    .pwm        (o_right_pwm)
  );

  assign o_period_end = period_end;
  assign o_timeout    = timeout;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver (CLK_DIV=2, SLEW_STEP=8, WATCHDOG_PERIODS=4,
// period 512 clk). The bench plays both FIFOs and keeps a per-period model
// of targets, duties and the watchdog.
module tb_motor_pwm_driver;

  localparam int MW     = 8;
  localparam int CLKDIV = 2;
  localparam int SLEW   = 8;
  localparam int WDP    = 4;
  localparam int PERIOD = 512;
  localparam int NP     = 72;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          o_left_pwm;
  logic          o_right_pwm;
  logic [MW-1:0] o_left_duty;
  logic [MW-1:0] o_right_duty;
  logic          o_period_end;
  logic          o_timeout;

  motor_pwm_driver_if #(.MW(MW)) fifo_if ();

  motor_pwm_driver #(
    .MOTOR_WIDTH      (MW),
    .CLK_DIV          (CLKDIV),
    .SLEW_STEP        (SLEW),
    .WATCHDOG_PERIODS (WDP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo         (fifo_if),
    .o_left_pwm   (o_left_pwm),
    .o_right_pwm  (o_right_pwm),
    .o_left_duty  (o_left_duty),
    .o_right_duty (o_right_duty),
    .o_period_end (o_period_end),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lq[$];
  int rq[$];

  logic          s_lrd, s_rrd, s_pe, s_lpwm, s_rpwm, s_to;
  logic [MW-1:0] s_ld, s_rd;

  int m_duty_l, m_duty_r, m_tgt_l, m_tgt_r, m_wd, m_to;
  int pe_cnt, pe_last, rd_cnt, rd_skew, hi_l, hi_r;
  int has_push, mode, vl, vr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sample mid-cycle, then act as the FIFO: data popped on rd_en appears
  // just after the edge, valid for the following cycle.
  task automatic cycle();
    @(negedge clk);
    s_lrd  = fifo_if.o_left_rd_en;
    s_rrd  = fifo_if.o_right_rd_en;
    s_pe   = o_period_end;
    s_lpwm = o_left_pwm;
    s_rpwm = o_right_pwm;
    s_to   = o_timeout;
    s_ld   = o_left_duty;
    s_rd   = o_right_duty;
    @(posedge clk);
    #1;
    if (s_lrd === 1'b1 && lq.size() > 0) fifo_if.i_left_motor = MW'(lq.pop_front());
    if (s_rrd === 1'b1 && rq.size() > 0) fifo_if.i_right_motor = MW'(rq.pop_front());
    fifo_if.i_left_empty  = (lq.size() == 0);
    fifo_if.i_right_empty = (rq.size() == 0);
  endtask

  task automatic push_l(input int v);
    lq.push_back(v);
    fifo_if.i_left_empty = 1'b0;
  endtask

  task automatic push_r(input int v);
    rq.push_back(v);
    fifo_if.i_right_empty = 1'b0;
  endtask

  task automatic flush();
    lq.delete();
    rq.delete();
    fifo_if.i_left_empty  = 1'b1;
    fifo_if.i_right_empty = 1'b1;
  endtask

  function automatic int slew_model(input int cur, input int tgt);
    if (tgt > cur) return (tgt - cur > SLEW) ? cur + SLEW : tgt;
    if (tgt < cur) return (cur - tgt > SLEW) ? cur - SLEW : tgt;
    return cur;
  endfunction

  function automatic int rand_cmd();
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 1) ? 255 : 0;
    return int'($urandom_range(0, 255));
  endfunction

  initial begin
    fifo_if.i_left_motor  = '0;
    fifo_if.i_right_motor = '0;
    fifo_if.i_left_empty  = 1'b1;
    fifo_if.i_right_empty = 1'b1;

    // Reset held with both FIFOs non-empty: no pops, outputs cleared.
    push_l(10);
    push_r(20);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("reset_rd_l", 32'(s_lrd), 0);
      check("reset_rd_r", 32'(s_rrd), 0);
      if (i >= 2) begin
        check("reset_duty_l", 32'(s_ld), 0);
        check("reset_duty_r", 32'(s_rd), 0);
        check("reset_pwm", 32'(s_lpwm | s_rpwm), 0);
        check("reset_pe_to", 32'(s_pe | s_to), 0);
      end
    end
    flush();
    reset = 1'b0;

    m_duty_l = 0; m_duty_r = 0; m_tgt_l = 0; m_tgt_r = 0; m_wd = 0; m_to = 0;

    for (int p = 0; p < NP; p++) begin
      has_push = 0; mode = 0; vl = 0; vr = 0;
      if (p >= 5 && p <= 22) begin
        has_push = 1; vl = 128; vr = 128;
      end else if (p >= 23 && p <= 40) begin
        has_push = 1; vl = 255; vr = 0; mode = (p == 23) ? 1 : 0;
      end else if (p == 41) begin
        has_push = 1; mode = 2; vl = 50; vr = 60;
      end else if (p >= 48) begin
        has_push = ($urandom_range(0, 3) != 0) ? 1 : 0;
        mode = int'($urandom_range(0, 2));
        vl = rand_cmd();
        vr = rand_cmd();
      end
      pe_cnt = 0; pe_last = 0; rd_cnt = 0; rd_skew = 0; hi_l = 0; hi_r = 0;

      for (int off = 0; off < PERIOD; off++) begin
        if (has_push != 0) begin
          if (mode == 0 && off == 50) begin push_l(vl); push_r(vr); end
          if (mode == 1 && off == 50) push_l(vl);
          if (mode == 1 && off == 150) push_r(vr);
          if (mode == 2 && off == 510) begin push_l(vl); push_r(vr); end
        end
        cycle();
        if (s_pe === 1'b1) begin
          pe_cnt++;
          if (off == PERIOD - 1) pe_last = 1;
        end
        if (s_lrd === 1'b1) rd_cnt++;
        if (s_lrd !== s_rrd) rd_skew++;
        if (s_lpwm === 1'b1) hi_l++;
        if (s_rpwm === 1'b1) hi_r++;
        if (off == 0) begin
          check("duty_l", 32'(s_ld), m_duty_l);
          check("duty_r", 32'(s_rd), m_duty_r);
          check("timeout", 32'(s_to), m_to);
        end
        if (has_push != 0 && mode == 1 && off == 149) begin
          check("lone_left_no_pop", rd_cnt, 0);
          check("lone_left_queue", lq.size(), 1);
        end
        if (has_push != 0 && mode != 2 && off == 200) begin
          m_tgt_l = vl; m_tgt_r = vr; m_wd = 0; m_to = 0;
          check("timeout_after_capture", 32'(s_to), 0);
        end
      end

      check("period_end_once", pe_cnt, 1);
      check("period_end_last_cycle", pe_last, 1);
      check("pops_per_period", rd_cnt, has_push);
      check("pop_pairing", rd_skew, 0);
      check("pwm_high_l", hi_l, 2 * m_duty_l);
      check("pwm_high_r", hi_r, 2 * m_duty_r);

      m_duty_l = slew_model(m_duty_l, m_tgt_l);
      m_duty_r = slew_model(m_duty_r, m_tgt_r);
      if (has_push != 0 && mode == 2) begin
        m_tgt_l = vl; m_tgt_r = vr; m_wd = 0; m_to = 0;
      end else if (m_wd < WDP) begin
        m_wd++;
        if (m_wd == WDP) begin
          m_to = 1; m_tgt_l = 0; m_tgt_r = 0;
        end
      end
    end

    // Reset landing on the capture cycle: the popped pair must be dropped.
    push_l(77);
    push_r(99);
    cycle();
    check("mid_reset_pop_issued", 32'(s_lrd & s_rrd), 1);
    reset = 1'b1;
    cycle();
    check("mid_reset_no_pop", 32'(s_lrd | s_rrd), 0);
    push_l(11);
    push_r(22);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("mid_reset_rd", 32'(s_lrd | s_rrd), 0);
      check("mid_reset_duty", 32'({s_ld, s_rd}), 0);
      check("mid_reset_flags", 32'({s_lpwm, s_rpwm, s_pe, s_to}), 0);
    end
    flush();
    reset = 1'b0;
    pe_cnt = 0; pe_last = 0; hi_l = 0;
    for (int off = 0; off < PERIOD; off++) begin
      cycle();
      if (s_pe === 1'b1) begin
        pe_cnt++;
        if (off == PERIOD - 1) pe_last = 1;
      end
      if (s_lpwm === 1'b1 || s_rpwm === 1'b1) hi_l++;
    end
    check("post_reset_period_end", pe_cnt, 1);
    check("post_reset_period_end_last", pe_last, 1);
    check("post_reset_pwm", hi_l, 0);
    cycle();
    check("post_reset_duty_l", 32'(s_ld), 0);
    check("post_reset_duty_r", 32'(s_rd), 0);
    check("post_reset_timeout", 32'(s_to), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
